ppu_cmd_queue: RTL
==================

PPU_CMD_QUEUE -- requirements
Module: ppu_cmd_queue

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- DEPTH, 8, number of 32-bit entries; power of two, range 2..64.
- AFULL_LVL, 6, occupancy at or above which almost_full asserts.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock; all state changes on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- ppu_send, in, 1, processor push strobe; one entry per cycle high.
- interface_data, in, 32, processor push data; sampled when ppu_send=1.
- cmd_data, out, 32, head entry presented to the PPU.
- cmd_valid, out, 1, head entry valid.
- cmd_ready, in, 1, PPU accepts the head entry when cmd_valid=1.
- count, out, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
- full, out, 1, count==DEPTH.
- almost_full, out, 1, count>=AFULL_LVL.
- overflow, out, 1, sticky dropped-push flag.
- clr_overflow, in, 1, clears overflow.

Function
REQ-003 The block SHALL be a first-word-fall-through FIFO between processor ppu_send/interface_data and the PPU command port.
REQ-004 A push SHALL occur on an edge where ppu_send=1 and (count<DEPTH or a pop occurs on the same edge).
REQ-005 A pop SHALL occur on an edge where cmd_valid=1 and cmd_ready=1.
REQ-006 Latency: data pushed at edge N SHALL appear on cmd_data with cmd_valid=1 after edge N when the queue was empty before N; there is no combinational path from ppu_send to cmd_valid.
REQ-007 cmd_valid SHALL equal (count!=0); cmd_data SHALL equal the oldest entry when cmd_valid=1 and 32'h0 when cmd_valid=0.
REQ-008 cmd_data SHALL remain stable while cmd_valid=1 and cmd_ready=0.
REQ-009 Simultaneous push and pop with count in 1..DEPTH SHALL leave count unchanged, write the new entry at the tail and advance the head.
REQ-010 Push when empty with cmd_ready=1 SHALL NOT pop on that edge; count becomes 1.
REQ-011 Push when full with no pop SHALL drop interface_data, leave contents and count unchanged, and set overflow on that edge.
REQ-012 overflow SHALL remain 1 until an edge with clr_overflow=1.
REQ-013 clr_overflow and an overflowing push on the same edge SHALL leave overflow=1, so set wins.
REQ-014 Read and write pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-015 count, full and almost_full SHALL be registered or derived only from registered state, and SHALL update on the same edge as the push or pop.
REQ-016 A pop when count==0 SHALL be impossible; cmd_ready while empty SHALL have no effect.

Reset
REQ-017 On rst_n=0 the block SHALL immediately and asynchronously force pointers=0, count=0, cmd_valid=0, cmd_data=0, full=0, almost_full=0 and overflow=0.
REQ-018 Storage array contents SHALL NOT require reset.
REQ-019 Reset asserted mid-transfer SHALL discard all queued entries; the first push after release SHALL be the head entry.
REQ-020 ppu_send asserted on the first edge after rst_n rises SHALL be accepted.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Single push: push 32'hDEADBEEF into the empty queue with cmd_ready=0 -> next cycle cmd_valid=1, cmd_data=DEADBEEF, count=1; cmd_data holds for 5 cycles.
- Fill and overflow: push 1..9 with DEPTH=8 and cmd_ready=0 -> full=1 after the 8th push, overflow=1 after the 9th, count=8; draining yields 1..8 in order with no 9.
- Simultaneous push/pop when full: queue holds 1..8, then push 32'hA5 with cmd_ready=1 on the same edge -> count stays 8, full stays 1, overflow stays 0, 32'hA5 exits last.
- Wrap-around: 20 back-to-back push/pop pairs with cmd_ready=1 and count held at 1 or 2 -> output sequence equals input sequence exactly, pointers wrap twice.
- Overflow priority: clr_overflow=1 on the same edge as an overflowing push -> overflow stays 1; clr_overflow alone on the next edge -> overflow=0.
- Reset mid-operation: count=5, then pulse rst_n low for 3 ns between edges -> outputs go to 0 immediately; after release, push 32'h12345000 -> cmd_data=12345000, count=1.

Source files
------------

// File: rtl/ppu_cmd_queue.sv
// First-word-fall-through command queue between the processor push port and the PPU.
// The head entry is held in its own register, so cmd_data, cmd_valid and the occupancy flags all come straight from flops.
module ppu_cmd_queue #(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ppu_send,
    input  logic [31:0]              interface_data,
    output logic [31:0]              cmd_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      head_r;
    logic             valid_r;
    logic             full_r;
    logic             afull_r;
    logic             overflow_r;

    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] rd_ptr_inc_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic [31:0]      head_next_s;
    logic             overflow_next_s;

    // Handshake decode, pointer/count update and next head selection.
    always_comb begin
        pop_s           = valid_r & cmd_ready;
        push_s          = ppu_send & (~full_r | pop_s);
        rd_ptr_inc_s    = rd_ptr_r + PTR_W'(1);
        wr_ptr_next_s   = wr_ptr_r;
        rd_ptr_next_s   = rd_ptr_r;
        count_next_s    = count_r;
        head_next_s     = head_r;
        overflow_next_s = overflow_r;

        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_inc_s;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase

        // The entry behind the head is already in storage when two or more are queued;
        // with a single entry the only possible successor is the word arriving now.
        if (pop_s) begin
            if (count_r >= CNT_W'(2)) begin
                head_next_s = mem_r[rd_ptr_inc_s];
            end else if (push_s) begin
                head_next_s = interface_data;
            end else begin
                head_next_s = 32'h0000_0000;
            end
        end else if (push_s && !valid_r) begin
            head_next_s = interface_data;
        end else begin
            head_next_s = head_r;
        end

        if (ppu_send && full_r && !pop_s) begin
            overflow_next_s = 1'b1;
        end else if (clr_overflow) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Control and head-of-queue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            head_r     <= 32'h0000_0000;
            valid_r    <= 1'b0;
            full_r     <= 1'b0;
            afull_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            head_r     <= head_next_s;
            valid_r    <= (count_next_s != CNT_W'(0));
            full_r     <= (count_next_s == CNT_W'(DEPTH));
            afull_r    <= (count_next_s >= CNT_W'(AFULL_LVL));
            overflow_r <= overflow_next_s;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= interface_data;
        end
    end

    assign cmd_data    = head_r;
    assign cmd_valid   = valid_r;
    assign count       = count_r;
    assign full        = full_r;
    assign almost_full = afull_r;
    assign overflow    = overflow_r;

endmodule
